// File: rtl/logical_unit.sv
// Bitwise logic slice of the 19-bit ALU: combinational AND/OR/XOR/NOT/NAND/NOR/XNOR result
// plus a registered copy with zero, odd-parity and illegal-opcode flags.

package constants;
  parameter int unsigned WORD_SIZE   = 19;
  parameter int unsigned OPCODE_SIZE = 5;
endpackage

package opcodes;
  parameter logic [constants::OPCODE_SIZE-1:0] OP_AND  = 5'd8;
  parameter logic [constants::OPCODE_SIZE-1:0] OP_OR   = 5'd9;
  parameter logic [constants::OPCODE_SIZE-1:0] OP_XOR  = 5'd10;
  parameter logic [constants::OPCODE_SIZE-1:0] OP_NOT  = 5'd11;
  parameter logic [constants::OPCODE_SIZE-1:0] OP_NAND = 5'd12;
  parameter logic [constants::OPCODE_SIZE-1:0] OP_NOR  = 5'd13;
  parameter logic [constants::OPCODE_SIZE-1:0] OP_XNOR = 5'd14;
endpackage

module logical_unit #(
  parameter int unsigned WORD_SIZE   = constants::WORD_SIZE,
  parameter int unsigned OPCODE_SIZE = constants::OPCODE_SIZE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [OPCODE_SIZE-1:0] opcode,
  input  logic [WORD_SIZE-1:0]   operand_1,
  input  logic [WORD_SIZE-1:0]   operand_2,
  output logic [WORD_SIZE-1:0]   out,
  output logic [WORD_SIZE-1:0]   out_q,
  output logic                   zero_q,
  output logic                   parity_q,
  output logic                   illegal_q
);

  logic illegal;

  // Unused encodings fall to the default so out is never X or held.
  always_comb begin
    out     = '0;
    illegal = 1'b0;
    case (opcode)
      opcodes::OP_AND:  out = operand_1 & operand_2;
      opcodes::OP_OR:   out = operand_1 | operand_2;
      opcodes::OP_XOR:  out = operand_1 ^ operand_2;
      opcodes::OP_NOT:  out = ~operand_1;
      opcodes::OP_NAND: out = ~(operand_1 & operand_2);
      opcodes::OP_NOR:  out = ~(operand_1 | operand_2);
      opcodes::OP_XNOR: out = ~(operand_1 ^ operand_2);
      default: begin
        out     = '0;
        illegal = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= '0;
      zero_q    <= 1'b1;
      parity_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      out_q     <= out;
      zero_q    <= (out == '0);
      parity_q  <= ^out;
      illegal_q <= illegal;
    end
  end

endmodule

// File: tb/tb_logical_unit.sv
// Self-checking bench for logical_unit: directed cases, reset behaviour and randomized
// stimulus against a per-bit truth-table reference model.

module tb_logical_unit;

  localparam logic [4:0] AND_C  = 5'd8;
  localparam logic [4:0] OR_C   = 5'd9;
  localparam logic [4:0] XOR_C  = 5'd10;
  localparam logic [4:0] NOT_C  = 5'd11;
  localparam logic [4:0] NAND_C = 5'd12;
  localparam logic [4:0] NOR_C  = 5'd13;
  localparam logic [4:0] XNOR_C = 5'd14;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  opcode;
  logic [18:0] operand_1;
  logic [18:0] operand_2;
  logic [18:0] out;
  logic [18:0] out_q;
  logic        zero_q;
  logic        parity_q;
  logic        illegal_q;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [18:0] exp_out;
  logic [4:0]  r_op;

  logical_unit dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .operand_1 (operand_1),
    .operand_2 (operand_2),
    .out       (out),
    .out_q     (out_q),
    .zero_q    (zero_q),
    .parity_q  (parity_q),
    .illegal_q (illegal_q)
  );

  always #5 clk = ~clk;

  function automatic bit is_legal(input logic [4:0] op);
    return op inside {AND_C, OR_C, XOR_C, NOT_C, NAND_C, NOR_C, XNOR_C};
  endfunction

  // Reference: each result bit from the count of ones among the two operand bits.
  function automatic logic [18:0] model(input logic [4:0] op, input logic [18:0] a,
                                        input logic [18:0] b);
    logic [18:0] r;
    int          s;
    r = '0;
    for (int i = 0; i < 19; i++) begin
      s = int'(a[i]) + int'(b[i]);
      case (op)
        AND_C:   r[i] = (s == 2);
        OR_C:    r[i] = (s >= 1);
        XOR_C:   r[i] = (s == 1);
        NOT_C:   r[i] = (a[i] == 1'b0);
        NAND_C:  r[i] = (s != 2);
        NOR_C:   r[i] = (s == 0);
        XNOR_C:  r[i] = (s != 1);
        default: r[i] = 1'b0;
      endcase
    end
    return r;
  endfunction

  function automatic logic odd_parity(input logic [18:0] v);
    int ones;
    ones = 0;
    for (int i = 0; i < 19; i++) ones += int'(v[i]);
    return logic'(ones % 2);
  endfunction

  task automatic check(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs away from the edge, check out, then check the registered copy after the edge.
  task automatic apply(input string tag, input logic r, input logic [4:0] op,
                       input logic [18:0] a, input logic [18:0] b);
    logic [18:0] e;
    rst       = r;
    opcode    = op;
    operand_1 = a;
    operand_2 = b;
    e         = model(op, a, b);
    #2;
    check({tag, " out"}, out, e);
    @(posedge clk);
    #1;
    if (r) begin
      check({tag, " out_q rst"}, out_q, 19'h0);
      check({tag, " zero_q rst"}, 19'(zero_q), 19'd1);
      check({tag, " parity_q rst"}, 19'(parity_q), 19'd0);
      check({tag, " illegal_q rst"}, 19'(illegal_q), 19'd0);
    end else begin
      check({tag, " out_q"}, out_q, e);
      check({tag, " zero_q"}, 19'(zero_q), 19'(e == 19'h0));
      check({tag, " parity_q"}, 19'(parity_q), 19'(odd_parity(e)));
      check({tag, " illegal_q"}, 19'(illegal_q), 19'(!is_legal(op)));
    end
  endtask

  initial begin
    rst = 1'b1; opcode = AND_C; operand_1 = '0; operand_2 = '0;
    @(negedge clk);

    // Reset state, with out still tracking inputs during reset
    apply("reset_nor", 1'b1, NOR_C, 19'h0, 19'h0);
    check("reset_out_tracks", out, 19'h7FFFF);

    // Directed vectors with literal expected values
    apply("and", 1'b0, AND_C, 19'b1010101010101010101, 19'b1100110011001100110);
    check("and_lit", out, 19'b1000100010001000100);
    apply("or", 1'b0, OR_C, 19'b1010101010101010101, 19'b1100110011001100110);
    check("or_lit", out, 19'b1110111011101110111);
    apply("xor", 1'b0, XOR_C, 19'b1010101010101010101, 19'b1100110011001100110);
    check("xor_lit", out, 19'b0110011001100110011);
    apply("not", 1'b0, NOT_C, 19'b1010101010101010101, 19'h0);
    check("not_lit", out, 19'b0101010101010101010);

    apply("nor00", 1'b0, NOR_C, 19'h0, 19'h0);
    check("nor_out_q_lit", out_q, 19'h7FFFF);
    check("nor_zero_lit", 19'(zero_q), 19'd0);
    check("nor_parity_lit", 19'(parity_q), 19'd1);

    apply("and_zero", 1'b0, AND_C, 19'h7FFFF, 19'h0);
    check("and_zero_lit", 19'(zero_q), 19'd1);

    apply("illegal", 1'b0, 5'd0, 19'h12345, 19'h7ABCD);
    check("illegal_out_lit", out, 19'h0);
    check("illegal_q_lit", 19'(illegal_q), 19'd1);

    // Opcode change with operands held
    apply("hold_nand", 1'b0, NAND_C, 19'h5A5A5, 19'h3C3C3);
    apply("hold_xnor", 1'b0, XNOR_C, 19'h5A5A5, 19'h3C3C3);

    // Reset mid-stream overrides capture
    apply("mid_rst", 1'b1, XNOR_C, 19'h5A5A5, 19'h3C3C3);
    apply("post_rst", 1'b0, OR_C, 19'h00001, 19'h00000);

    // Randomized: biased toward legal opcodes but covering every encoding
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) r_op = 5'($urandom_range(0, 31));
      else r_op = 5'($urandom_range(8, 14));
      apply("rand", ($urandom_range(0, 19) == 0), r_op, 19'($urandom), 19'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
